dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between the pipeline M stage (port P) and a

---
 rtl/dmem_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the pipeline M stage
// (port P) and a loader/debug master (port L).
// Grants are combinational, so one access reaches the memory each cycle. Read data
// is registered for the port that won. The M stage is stalled whenever it is refused.
// The loader can take burst ownership with l_lock. That ownership is bounded by
// MAX_BURST grants. L is also protected from starvation by STARVE_LIMIT.
// Optional feature macro: DMEM_ARB_STATS_EN adds the stat_conflict and stat_lburst
// counters. The default build leaves the macro undefined.

module dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,   // 1..15
  parameter int MAX_BURST    = 8    // 2..255
) (
  input  logic          clk,
  input  logic          rst,
  // M-stage port
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic          p_gnt,
  output logic [DW-1:0] p_rdata,
  output logic          p_rvalid,
  output logic          stall_M,
  // loader / debug port
  input  logic          l_req,
  input  logic          l_we,
  input  logic          l_lock,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic [DW-1:0] l_rdata,
  output logic          l_rvalid,
  // data memory side
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   stat_conflict,
  output logic [15:0]   stat_lburst
`endif
);

  localparam int SW = 4;  // starvation counter width, holds up to 15
  localparam int BW = 8;  // burst counter width, holds up to 255

  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LBURST = 1'b1
  } state_t;

  state_t        state_r;
  logic [SW-1:0] starve_r;
  logic [BW-1:0] burst_r;
  logic          p_gnt_s;
  logic          l_gnt_s;

  // Grant decision: L owns the memory in LBURST. In ARB, P wins unless L has starved.
  always_comb begin
    p_gnt_s = 1'b0;
    l_gnt_s = 1'b0;
    if (rst) begin
      p_gnt_s = 1'b0;
      l_gnt_s = 1'b0;
    end else begin
      case (state_r)
        ARB: begin
          if (p_req) begin
            if (l_req && (starve_r == STARVE_MAX)) begin
              l_gnt_s = 1'b1;
            end else begin
              p_gnt_s = 1'b1;
            end
          end else if (l_req) begin
            l_gnt_s = 1'b1;
          end else begin
            p_gnt_s = 1'b0;
            l_gnt_s = 1'b0;
          end
        end
        LBURST: begin
          if (l_req) begin
            l_gnt_s = 1'b1;
          end else begin
            l_gnt_s = 1'b0;
          end
        end
        default: begin
          p_gnt_s = 1'b0;
          l_gnt_s = 1'b0;
        end
      endcase
    end
  end

  // Memory-side mux: route the winner's address and data, and default to P when idle.
  always_comb begin
    mem_addr  = p_addr;
    mem_wdata = p_wdata;
    if (l_gnt_s) begin
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
    end else begin
      mem_addr  = p_addr;
      mem_wdata = p_wdata;
    end
  end

  assign mem_we  = (p_gnt_s & p_we) | (l_gnt_s & l_we);
  assign p_gnt   = p_gnt_s;
  assign l_gnt   = l_gnt_s;
  assign stall_M = p_req & ~p_gnt_s;

  // Arbitration FSM with its burst-length and starvation counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ARB;
      burst_r  <= {BW{1'b0}};
      starve_r <= {SW{1'b0}};
    end else begin
      // A refused L request ages; a grant or a dropped request clears the age.
      if (l_req && !l_gnt_s) begin
        if (starve_r != STARVE_MAX) begin
          starve_r <= starve_r + 1'b1;
        end else begin
          starve_r <= starve_r;
        end
      end else begin
        starve_r <= {SW{1'b0}};
      end

      case (state_r)
        ARB: begin
          if (l_gnt_s && l_lock) begin
            state_r <= LBURST;
            burst_r <= {{(BW-1){1'b0}}, 1'b1};
          end else begin
            state_r <= ARB;
            burst_r <= {BW{1'b0}};
          end
        end
        LBURST: begin
          if (!l_req) begin
            state_r <= ARB;
            burst_r <= {BW{1'b0}};
          end else if (l_gnt_s) begin
            // The burst ends on the grant that releases the lock or that hits the length cap.
            if (!l_lock || (burst_r == BURST_LAST)) begin
              state_r <= ARB;
              burst_r <= {BW{1'b0}};
            end else begin
              state_r <= LBURST;
              burst_r <= burst_r + 1'b1;
            end
          end else begin
            state_r <= LBURST;
            burst_r <= burst_r;
          end
        end
        default: begin
          state_r <= ARB;
          burst_r <= {BW{1'b0}};
        end
      endcase
    end
  end

  // Read-data capture: the winner's read data is registered and flagged valid for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_rvalid <= 1'b0;
      l_rvalid <= 1'b0;
      p_rdata  <= {DW{1'b0}};
      l_rdata  <= {DW{1'b0}};
    end else begin
      p_rvalid <= p_gnt_s & ~p_we;
      l_rvalid <= l_gnt_s & ~l_we;
      if (p_gnt_s && !p_we) begin
        p_rdata <= mem_rdata;
      end else begin
        p_rdata <= p_rdata;
      end
      if (l_gnt_s && !l_we) begin
        l_rdata <= mem_rdata;
      end else begin
        l_rdata <= l_rdata;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Saturating statistics: cycles where both ports request, and entries into LBURST.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_conflict <= 16'd0;
      stat_lburst   <= 16'd0;
    end else begin
      if (p_req && l_req && (stat_conflict != 16'hFFFF)) begin
        stat_conflict <= stat_conflict + 16'd1;
      end else begin
        stat_conflict <= stat_conflict;
      end
      if ((state_r == ARB) && l_gnt_s && l_lock && (stat_lburst != 16'hFFFF)) begin
        stat_lburst <= stat_lburst + 16'd1;
      end else begin
        stat_lburst <= stat_lburst;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter.
// The stimulus drives one directed vector per cycle and checks grants, stall and the
// memory strobe. It pushes expected read data, tagged with the due cycle, into
// per-port queues. A separate monitor pops from those queues and checks rvalid and rdata.

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p_req = 1'b0, p_we = 1'b0;
  logic [31:0] p_addr = 32'd0, p_wdata = 32'd0;
  logic        p_gnt, p_rvalid, stall_M;
  logic [31:0] p_rdata;
  logic        l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
  logic [31:0] l_addr = 32'd0, l_wdata = 32'd0;
  logic        l_gnt, l_rvalid;
  logic [31:0] l_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_conflict, stat_lburst;
`endif

  logic [31:0] mem [0:63];
  logic        mem_init = 1'b1;
  int          cyc_n = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    int          due;
    logic [31:0] d;
  } rsp_t;
  rsp_t p_q[$];
  rsp_t l_q[$];

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_rdata(p_rdata), .p_rvalid(p_rvalid), .stall_M(stall_M),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rdata(l_rdata), .l_rvalid(l_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stat_conflict(stat_conflict), .stat_lburst(stat_lburst)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: asynchronous read, and writes commit on the clock edge.
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h5A5A_0000 + i;
      mem[4] <= 32'hCAFE_F00D;
    end else if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h expected %h", nm, cyc_n, act, exp);
    end
  endtask

  // One directed cycle: apply the inputs, check the combinational outputs, queue reads.
  task automatic cyc(input logic r,
                     input logic pr, input logic pw, input logic [31:0] pa, input logic [31:0] pd,
                     input logic lr, input logic lw, input logic lk, input logic [31:0] la,
                     input logic [31:0] ld, input logic epg, input logic elg,
                     input logic [31:0] erd);
    rsp_t e;
    @(posedge clk);
    #1;
    rst = r; p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
    l_req = lr; l_we = lw; l_lock = lk; l_addr = la; l_wdata = ld;
    @(negedge clk);
    chk("p_gnt", {31'd0, p_gnt}, {31'd0, epg});
    chk("l_gnt", {31'd0, l_gnt}, {31'd0, elg});
    chk("stall_M", {31'd0, stall_M}, {31'd0, pr & ~epg});
    chk("mem_we", {31'd0, mem_we}, {31'd0, (epg & pw) | (elg & lw)});
    chk("mem_addr", mem_addr, elg ? la : pa);
    e.due = cyc_n + 1;
    e.d   = erd;
    if (epg && !pw) p_q.push_back(e);
    if (elg && !lw) l_q.push_back(e);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  // Response monitor: checks that read data shows up exactly on its due cycle.
  always @(negedge clk) begin
    if (p_q.size() > 0 && p_q[0].due == cyc_n) begin
      chk("p_rvalid", {31'd0, p_rvalid}, 32'd1);
      chk("p_rdata", p_rdata, p_q[0].d);
      void'(p_q.pop_front());
    end else if (p_rvalid === 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL p_rvalid_unexpected (cycle %0d): got 1 expected 0", cyc_n);
    end
    if (l_q.size() > 0 && l_q[0].due == cyc_n) begin
      chk("l_rvalid", {31'd0, l_rvalid}, 32'd1);
      chk("l_rdata", l_rdata, l_q[0].d);
      void'(l_q.pop_front());
    end else if (l_rvalid === 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL l_rvalid_unexpected (cycle %0d): got 1 expected 0", cyc_n);
    end
  end

  // Watchdog: the stimulus is fixed length, so this only fires if the simulation wedges.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: requests are ignored, and registered outputs are zero.
    cyc(1'b1, 1'b1, 1'b1, 32'h10, 32'h1, 1'b1, 1'b1, 1'b1, 32'h20, 32'h2, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 32'h10, 32'h1, 1'b1, 1'b1, 1'b1, 32'h20, 32'h2, 1'b0, 1'b0, 32'd0);
    chk("rst_p_rvalid", {31'd0, p_rvalid}, 32'd0);
    chk("rst_l_rvalid", {31'd0, l_rvalid}, 32'd0);
    chk("rst_p_rdata", p_rdata, 32'd0);
    chk("rst_l_rdata", l_rdata, 32'd0);
    mem_init = 1'b0;
    idle();

    // 1: P read only.
    cyc(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'hCAFE_F00D);
    idle();

    // 2: starvation. P wins 4 cycles, L wins the 5th, then P wins again.
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b1, 1'b0, 32'h08, 32'd0, 1'b1, 1'b0, 1'b0, 32'h0C, 32'd0, 1'b1, 1'b0, 32'h5A5A_0002);
    cyc(1'b0, 1'b1, 1'b0, 32'h08, 32'd0, 1'b1, 1'b0, 1'b0, 32'h0C, 32'd0, 1'b0, 1'b1, 32'h5A5A_0003);
    cyc(1'b0, 1'b1, 1'b0, 32'h08, 32'd0, 1'b1, 1'b0, 1'b0, 32'h0C, 32'd0, 1'b1, 1'b0, 32'h5A5A_0002);
    idle();

    // 3: locked L write burst against a busy P. The burst is capped at 8 grants.
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b1, 1'b0, 32'h08, 32'd0, 1'b1, 1'b1, 1'b1, 32'h20, 32'hB000_0000, 1'b1, 1'b0, 32'h5A5A_0002);
    for (int k = 0; k < 8; k++)
      cyc(1'b0, 1'b1, 1'b0, 32'h08, 32'd0, 1'b1, 1'b1, 1'b1, 32'h20 + 32'(4 * k), 32'hB000_0000 + 32'(k),
          1'b0, 1'b1, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'h08, 32'd0, 1'b1, 1'b1, 1'b1, 32'h40, 32'hDEAD_0000, 1'b1, 1'b0, 32'h5A5A_0002);
    idle();
    for (int k = 0; k < 8; k++)
      cyc(1'b0, 1'b1, 1'b0, 32'h20 + 32'(4 * k), 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0,
          1'b1, 1'b0, 32'hB000_0000 + 32'(k));
    idle();

    // 4: the lock is dropped on the 3rd L grant, so P is served the next cycle.
    cyc(1'b0, 1'b0, 1'b0, 32'h08, 32'd0, 1'b1, 1'b1, 1'b1, 32'h40, 32'hC000_0000, 1'b0, 1'b1, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'h08, 32'd0, 1'b1, 1'b1, 1'b1, 32'h44, 32'hC000_0001, 1'b0, 1'b1, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'h08, 32'd0, 1'b1, 1'b1, 1'b0, 32'h48, 32'hC000_0002, 1'b0, 1'b1, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'h08, 32'd0, 1'b1, 1'b1, 1'b0, 32'h4C, 32'hC000_0003, 1'b1, 1'b0, 32'h5A5A_0002);
    idle();
    cyc(1'b0, 1'b1, 1'b0, 32'h48, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'hC000_0002);
    cyc(1'b0, 1'b1, 1'b0, 32'h4C, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h5A5A_0013);
    idle();

    // 5: reset in the 4th cycle of a locked L read burst.
    cyc(1'b0, 1'b0, 1'b0, 32'h08, 32'd0, 1'b1, 1'b0, 1'b1, 32'h0C, 32'd0, 1'b0, 1'b1, 32'h5A5A_0003);
    cyc(1'b0, 1'b1, 1'b0, 32'h08, 32'd0, 1'b1, 1'b0, 1'b1, 32'h10, 32'd0, 1'b0, 1'b1, 32'hCAFE_F00D);
    cyc(1'b0, 1'b1, 1'b0, 32'h08, 32'd0, 1'b1, 1'b0, 1'b1, 32'h14, 32'd0, 1'b0, 1'b1, 32'h5A5A_0005);
    cyc(1'b1, 1'b1, 1'b0, 32'h08, 32'd0, 1'b1, 1'b0, 1'b1, 32'h18, 32'd0, 1'b0, 1'b0, 32'd0);
    idle();
    chk("mid_rst_p_rvalid", {31'd0, p_rvalid}, 32'd0);
    chk("mid_rst_l_rvalid", {31'd0, l_rvalid}, 32'd0);
    chk("mid_rst_p_rdata", p_rdata, 32'd0);
    chk("mid_rst_l_rdata", l_rdata, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 1'b0, 1'b1, 32'h0C, 32'd0, 1'b1, 1'b0, 32'hCAFE_F00D);
    idle();

`ifdef DMEM_ARB_STATS_EN
    // 6: statistics after a fresh reset: 10 conflict cycles and 2 bursts.
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    idle();
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 1'b1, 1'b0, 32'h08, 32'd0, 1'b1, 1'b0, 1'b0, 32'h0C, 32'd0,
          (i % 5) != 4, (i % 5) == 4, ((i % 5) == 4) ? 32'h5A5A_0003 : 32'h5A5A_0002);
    for (int b = 0; b < 2; b++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 32'h0C, 32'd0, 1'b0, 1'b1, 32'h5A5A_0003);
      cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'h0C, 32'd0, 1'b0, 1'b1, 32'h5A5A_0003);
    end
    idle();
    chk("stat_conflict", {16'd0, stat_conflict}, 32'd10);
    chk("stat_lburst", {16'd0, stat_lburst}, 32'd2);
`endif

    idle();
    idle();
    chk("p_q_drained", p_q.size(), 32'd0);
    chk("l_q_drained", l_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
